// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery into a holding register with sticky error flags.
// Define UART_RX_MAJORITY_EN to take each bit as the majority of three consecutive ticks.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       sample_tick,
  output logic [7:0] data,
  output logic       ready,
  input  logic       read_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rx_meta, rx_s;
  logic             bitv;
  logic             stop_good, stop_bad;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n)           hist <= 3'b111;
    else if (sample_tick) hist <= {hist[1:0], rx_s};
  end

  assign bitv = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n)           hist <= 2'b11;
    else if (sample_tick) hist <= {hist[0], rx_s};
  end

  assign bitv = hist[0];
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!hist[0] && hist[1]) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            if (bitv) begin
              state_d = IDLE;
            end else begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = DATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shreg_d = {bitv, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            stop_good = bitv;
            stop_bad  = ~bitv;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A good-frame load takes priority over a simultaneous read_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data      <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stop_good) begin
        data    <= shreg_q;
        ready   <= 1'b1;
        overrun <= ~read_ack & (ready | overrun);
      end else if (read_ack) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
      if (stop_bad)      frame_err <= 1'b1;
      else if (read_ack) frame_err <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences,
// with expected holding-register state queued per frame and checked when busy falls.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       sample_tick = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       read_ack = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       r;
    logic       fe;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       ack;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  uart_rx #(.OVERSAMPLE(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .sample_tick(sample_tick),
    .data(data), .ready(ready), .read_ack(read_ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every busy fall outside reset ends one frame or glitch.
  logic busy_q = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && busy_q && !busy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: busy fell with data=%0h but nothing expected", data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(data), 32'(e.d));
        chk("sb_ready", 32'(ready), 32'(e.r));
        chk("sb_frame_err", 32'(frame_err), 32'(e.fe));
        chk("sb_overrun", 32'(overrun), 32'(e.ov));
      end
    end
    busy_q = busy;
  end

  task automatic tick(input logic v);
    rx_in = v;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
  endtask

  function automatic logic [159:0] build_frame(input logic [7:0] b, input logic stop, input int spike);
    logic [159:0] f;
    for (int i = 0; i < 160; i++) begin
      int bi;
      bi = i / 16;
      if (bi == 0)      f[i] = 1'b0;
      else if (bi <= 8) f[i] = b[bi-1];
      else              f[i] = stop;
    end
    if (spike >= 0) f[spike] = 1'b1;
    return f;
  endfunction

  task automatic send_range(input logic [159:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) tick(f[i]);
  endtask

  task automatic push(input logic [7:0] d, input logic r, input logic fe, input logic ov);
    exp_t e;
    e.d = d; e.r = r; e.fe = fe; e.ov = ov;
    sb.push_back(e);
  endtask

  initial begin
    logic [159:0] f;
    logic         saw_busy;
    logic [7:0]   spike_exp;

    vecs[0] = '{b: 8'hA3, stop: 1'b1, ack: 1'b0, e: '{d: 8'hA3, r: 1'b1, fe: 1'b0, ov: 1'b0}};
    vecs[1] = '{b: 8'h0F, stop: 1'b1, ack: 1'b0, e: '{d: 8'h0F, r: 1'b1, fe: 1'b0, ov: 1'b1}};
    vecs[2] = '{b: 8'hC1, stop: 1'b0, ack: 1'b0, e: '{d: 8'h0F, r: 1'b1, fe: 1'b1, ov: 1'b1}};
    vecs[3] = '{b: 8'h3C, stop: 1'b1, ack: 1'b1, e: '{d: 8'h3C, r: 1'b1, fe: 1'b0, ov: 1'b0}};
    vecs[4] = '{b: 8'hFF, stop: 1'b1, ack: 1'b1, e: '{d: 8'hFF, r: 1'b1, fe: 1'b0, ov: 1'b0}};
    vecs[5] = '{b: 8'h00, stop: 1'b1, ack: 1'b0, e: '{d: 8'h00, r: 1'b1, fe: 1'b0, ov: 1'b1}};
    vecs[6] = '{b: 8'h80, stop: 1'b0, ack: 1'b1, e: '{d: 8'h00, r: 1'b0, fe: 1'b1, ov: 1'b0}};

    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick(1'b1);

    // 0x55 with a cycle-exact look at the stop-bit sample tick.
    f = build_frame(8'h55, 1'b1, -1);
    push(8'h55, 1'b1, 1'b0, 1'b0);
    send_range(f, 0, 152);
    chk("pre_stop_ready", 32'(ready), 32'h0);
    chk("pre_stop_busy", 32'(busy), 32'h1);
    send_range(f, 153, 153);
    chk("stop_ready", 32'(ready), 32'h1);
    chk("stop_data", 32'(data), 32'h55);
    chk("stop_busy", 32'(busy), 32'h0);
    send_range(f, 154, 159);
    ack();
    chk("ack_ready", 32'(ready), 32'h0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ack) ack();
      push(vecs[v].e.d, vecs[v].e.r, vecs[v].e.fe, vecs[v].e.ov);
      send_range(build_frame(vecs[v].b, vecs[v].stop, -1), 0, 159);
      if (!vecs[v].stop) repeat (4) tick(1'b1);
    end

    // Bad stop bit followed by a long break: no retrigger.
    push(8'h00, 1'b0, 1'b1, 1'b0);
    send_range(build_frame(8'h55, 1'b0, -1), 0, 159);
    saw_busy = 1'b0;
    for (int i = 0; i < 640; i++) begin
      tick(1'b0);
      saw_busy |= busy;
    end
    chk("break_busy", 32'(saw_busy), 32'h0);
    repeat (8) tick(1'b1);

    // 4-tick low pulse: START entered, glitch rejected.
    push(8'h00, 1'b0, 1'b1, 1'b0);
    saw_busy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(i < 4 ? 1'b0 : 1'b1);
      saw_busy |= busy;
    end
    chk("glitch_saw_busy", 32'(saw_busy), 32'h1);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    chk("glitch_ready", 32'(ready), 32'h0);

    // Reset in the middle of bit 4.
    ack();
    push(8'h12, 1'b1, 1'b0, 1'b0);
    send_range(build_frame(8'h12, 1'b1, -1), 0, 159);
    send_range(build_frame(8'h99, 1'b1, -1), 0, 84);
    @(negedge clk);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_ready", 32'(ready), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (8) tick(1'b1);
    push(8'h7E, 1'b1, 1'b0, 1'b0);
    send_range(build_frame(8'h7E, 1'b1, -1), 0, 159);

    // One-tick spike at the bit-3 sample point.
    ack();
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'h00;
`else
    spike_exp = 8'h08;
`endif
    push(spike_exp, 1'b1, 1'b0, 1'b0);
    send_range(build_frame(8'h00, 1'b1, 72), 0, 159);
    repeat (4) tick(1'b1);

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
